// File: rtl/junction_pkg.sv
// Shared types and constants for the two-road junction controller.
// Holds the state enum (codes double as the external phase value), the
// lamp encodings, the elapsed-counter width and a lamp decode helper.
// Optional feature macro: JUNCTION_PED_EN adds the PED_WALK state (code 9).
package junction_pkg;

  localparam int unsigned ELAPSED_W = 8;
  localparam int unsigned LIGHT_W   = 3;
  localparam int unsigned PHASE_W   = 4;

  // Lamp encoding {red, amber, green}
  localparam logic [LIGHT_W-1:0] LIGHT_RED      = 3'b100;
  localparam logic [LIGHT_W-1:0] LIGHT_REDAMBER = 3'b110;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN    = 3'b001;
  localparam logic [LIGHT_W-1:0] LIGHT_AMBER    = 3'b010;

  typedef enum logic [PHASE_W-1:0] {
    A_GO       = 4'd0,
    A_AMBER    = 4'd1,
    ALLRED_AB  = 4'd2,
    B_REDAMBER = 4'd3,
    B_GO       = 4'd4,
    B_AMBER    = 4'd5,
    ALLRED_BA  = 4'd6,
    A_REDAMBER = 4'd7,
    FAULT      = 4'd8
`ifdef JUNCTION_PED_EN
    ,
    PED_WALK   = 4'd9
`endif
  } state_e;

  typedef struct packed {
    logic [LIGHT_W-1:0] a;
    logic [LIGHT_W-1:0] b;
  } lights_t;

  // Lamp pattern for a state; the road not being served always shows red.
  function automatic lights_t decode_lights(input state_e s);
    lights_t l;
    l.a = LIGHT_RED;
    l.b = LIGHT_RED;
    case (s)
      A_GO:       l.a = LIGHT_GREEN;
      A_AMBER:    l.a = LIGHT_AMBER;
      A_REDAMBER: l.a = LIGHT_REDAMBER;
      B_GO:       l.b = LIGHT_GREEN;
      B_AMBER:    l.b = LIGHT_AMBER;
      B_REDAMBER: l.b = LIGHT_REDAMBER;
      default:    ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/junction_controller_phase_timer.sv
// Elapsed-tick counter for the current phase.
// Ports: clk, rst_n (async, active-low), clear (state entry), tick (timebase
// strobe), elapsed (ticks since entry, saturating at all-ones).
module phase_timer
  import junction_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 tick,
  output logic [ELAPSED_W-1:0] elapsed
);

  localparam logic [ELAPSED_W-1:0] SAT = '1;

  // Clear has priority so a new phase always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed <= '0;
    end else if (clear) begin
      elapsed <= '0;
    end else if (tick && (elapsed != SAT)) begin
      elapsed <= elapsed + ELAPSED_W'(1);
    end
  end

endmodule

// File: rtl/junction_controller.sv
// Two-road junction signal controller with demand-actuated green,
// fixed amber / red+amber / all-red clearance and a fault safe state.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   tick               one-cycle timebase strobe; all timed exits happen on it
//   req_a, req_b       vehicle demand levels for roads A and B
//   fault              forces both roads red while high
//   lights_a, lights_b {red,amber,green} lamps, registered
//   phase              current state code, registered
//   ped_req, ped_walk  pedestrian button / walk lamp (JUNCTION_PED_EN only)
// Optional feature macro: JUNCTION_PED_EN inserts a pedestrian walk phase
// after an all-red clearance when a pedestrian request is pending.
module junction_controller
  import junction_pkg::*;
#(
  parameter int unsigned T_MIN_GREEN = 4,
  parameter int unsigned T_MAX_GREEN = 12,
  parameter int unsigned T_AMBER     = 2,
  parameter int unsigned T_REDAMBER  = 1,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_WALK      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               req_a,
  input  logic               req_b,
  input  logic               fault,
`ifdef JUNCTION_PED_EN
  input  logic               ped_req,
  output logic               ped_walk,
`endif
  output logic [LIGHT_W-1:0] lights_a,
  output logic [LIGHT_W-1:0] lights_b,
  output logic [PHASE_W-1:0] phase
);

  localparam int unsigned CNT_W = ELAPSED_W + 1;

  // Last elapsed value of each fixed-length phase (exit when reached on a tick).
  localparam logic [ELAPSED_W-1:0] AMBER_LAST    = ELAPSED_W'(T_AMBER - 1);
  localparam logic [ELAPSED_W-1:0] REDAMBER_LAST = ELAPSED_W'(T_REDAMBER - 1);
  localparam logic [ELAPSED_W-1:0] ALLRED_LAST   = ELAPSED_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0]     MIN_GREEN_CNT = CNT_W'(T_MIN_GREEN);
  localparam logic [CNT_W-1:0]     MAX_GREEN_CNT = CNT_W'(T_MAX_GREEN);
`ifdef JUNCTION_PED_EN
  localparam logic [ELAPSED_W-1:0] WALK_LAST     = ELAPSED_W'(T_WALK - 1);
`endif

  // Elaboration-time guard on timing parameters.
  if ((T_MIN_GREEN < 1) || (T_MIN_GREEN > 255) ||
      (T_MAX_GREEN < 1) || (T_MAX_GREEN > 255) ||
      (T_AMBER < 1)     || (T_AMBER > 255)     ||
      (T_REDAMBER < 1)  || (T_REDAMBER > 255)  ||
      (T_ALLRED < 1)    || (T_ALLRED > 255)    ||
      (T_WALK < 1)      || (T_WALK > 255)      ||
      (T_MAX_GREEN < T_MIN_GREEN)) begin : g_param_check
    $error("junction_controller: timing parameter out of range");
  end

  state_e                 state_q, state_d;
  logic                   pend_a_q, pend_a_d;
  logic                   pend_b_q, pend_b_d;
  logic [ELAPSED_W-1:0]   elapsed;
  logic [CNT_W-1:0]       el_inc;
  logic                   a_green_done, b_green_done;
  logic                   timer_clear;
  lights_t                lights_d;
`ifdef JUNCTION_PED_EN
  logic                   pend_ped_q, pend_ped_d;
  logic                   ped_dir_b_q, ped_dir_b_d;
`endif

  phase_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .tick    (tick),
    .elapsed (elapsed)
  );

  // Ticks completed including the current one, used for green limits.
  assign el_inc       = {1'b0, elapsed} + CNT_W'(1);
  assign a_green_done = (el_inc >= MAX_GREEN_CNT) || ((el_inc >= MIN_GREEN_CNT) && !req_a);
  assign b_green_done = (el_inc >= MAX_GREEN_CNT) || ((el_inc >= MIN_GREEN_CNT) && !req_b);
  assign timer_clear  = (state_d != state_q);

  // Next-state, demand latches and next output values.
  always_comb begin
    state_d  = state_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
`ifdef JUNCTION_PED_EN
    pend_ped_d  = pend_ped_q;
    ped_dir_b_d = ped_dir_b_q;
`endif

    if (fault) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        A_GO:       if (tick && pend_b_q && a_green_done) state_d = A_AMBER;
        A_AMBER:    if (tick && (elapsed == AMBER_LAST)) state_d = ALLRED_AB;
        ALLRED_AB:  if (tick && (elapsed == ALLRED_LAST)) begin
`ifdef JUNCTION_PED_EN
                      if (pend_ped_q) begin
                        state_d     = PED_WALK;
                        ped_dir_b_d = 1'b1;
                      end else
`endif
                      state_d = B_REDAMBER;
                    end
        B_REDAMBER: if (tick && (elapsed == REDAMBER_LAST)) state_d = B_GO;
        B_GO:       if (tick && pend_a_q && b_green_done) state_d = B_AMBER;
        B_AMBER:    if (tick && (elapsed == AMBER_LAST)) state_d = ALLRED_BA;
        ALLRED_BA:  if (tick && (elapsed == ALLRED_LAST)) begin
`ifdef JUNCTION_PED_EN
                      if (pend_ped_q) begin
                        state_d     = PED_WALK;
                        ped_dir_b_d = 1'b0;
                      end else
`endif
                      state_d = A_REDAMBER;
                    end
        A_REDAMBER: if (tick && (elapsed == REDAMBER_LAST)) state_d = A_GO;
        FAULT:      state_d = ALLRED_BA;
`ifdef JUNCTION_PED_EN
        PED_WALK:   if (tick && (elapsed == WALK_LAST))
                      state_d = ped_dir_b_q ? B_REDAMBER : A_REDAMBER;
`endif
        default:    state_d = ALLRED_BA;
      endcase
    end

    // Demand latches: set by opposing-road request, cleared when served.
    if (fault) begin
      pend_a_d = 1'b0;
      pend_b_d = 1'b0;
`ifdef JUNCTION_PED_EN
      pend_ped_d = 1'b0;
`endif
    end else begin
      if (req_a && (state_q != A_GO) && (state_q != A_REDAMBER)) pend_a_d = 1'b1;
      if (req_b && (state_q != B_GO) && (state_q != B_REDAMBER)) pend_b_d = 1'b1;
      if ((state_d == A_GO) && (state_q != A_GO)) pend_a_d = 1'b0;
      if ((state_d == B_GO) && (state_q != B_GO)) pend_b_d = 1'b0;
`ifdef JUNCTION_PED_EN
      if (ped_req && (state_q != PED_WALK)) pend_ped_d = 1'b1;
      if ((state_d == PED_WALK) && (state_q != PED_WALK)) pend_ped_d = 1'b0;
`endif
    end

    lights_d = decode_lights(state_d);
  end

  // State, latches and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALLRED_BA;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      lights_a <= LIGHT_RED;
      lights_b <= LIGHT_RED;
      phase    <= PHASE_W'(ALLRED_BA);
`ifdef JUNCTION_PED_EN
      pend_ped_q  <= 1'b0;
      ped_dir_b_q <= 1'b0;
      ped_walk    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      lights_a <= lights_d.a;
      lights_b <= lights_d.b;
      phase    <= PHASE_W'(state_d);
`ifdef JUNCTION_PED_EN
      pend_ped_q  <= pend_ped_d;
      ped_dir_b_q <= ped_dir_b_d;
      ped_walk    <= (state_d == PED_WALK);
`endif
    end
  end

endmodule

// File: doc/junction_controller.md
JUNCTION_CONTROLLER -- requirements
Module: junction_controller

Interface
REQ-001 Parameters, one per line (name, default, meaning); each SHALL be 1..255:
  T_MIN_GREEN  4   minimum green, ticks
  T_MAX_GREEN  12  maximum green while own demand persists, ticks (>= T_MIN_GREEN)
  T_AMBER      2   amber duration, ticks
  T_REDAMBER   1   red+amber duration, ticks
  T_ALLRED     1   all-red clearance, ticks
  T_WALK       6   pedestrian walk, ticks
REQ-002 Ports (name direction width meaning):
  clk       in   1  single clock, rising edge
  rst_n     in   1  asynchronous, active-low reset
  tick      in   1  one-cycle timebase strobe
  req_a     in   1  road A vehicle demand, level
  req_b     in   1  road B vehicle demand, level
  fault     in   1  force safe state, level
  lights_a  out  3  road A {red,amber,green}, bit2=red
  lights_b  out  3  road B, same encoding
  phase     out  4  current state code
  ped_req   in   1  pedestrian button (JUNCTION_PED_EN only)
  ped_walk  out  1  walk lamp (JUNCTION_PED_EN only)

Function
REQ-003 States SHALL be A_GO, A_AMBER, ALLRED_AB, B_REDAMBER, B_GO, B_AMBER, ALLRED_BA, A_REDAMBER, FAULT (plus PED_WALK with macro).
REQ-004 Light encoding: red 100, red+amber 110, green 001, amber 010; the non-served road SHALL show 100 in every state; FAULT shows 100/100.
REQ-005 Outputs SHALL be Moore, decoded from the state register only.
REQ-006 Elapsed counter: 8 bits, cleared on every state entry, +1 on tick, saturates at 255.
REQ-007 Non-fault transitions SHALL occur only on edges where tick=1; "lasts T" means exit on the tick edge where elapsed==T-1.
REQ-008 Fixed states: A_AMBER/B_AMBER last T_AMBER, ALLRED_* last T_ALLRED, *_REDAMBER last T_REDAMBER; sequence A_GO->A_AMBER->ALLRED_AB->B_REDAMBER->B_GO->B_AMBER->ALLRED_BA->A_REDAMBER->A_GO.
REQ-009 Opposing demand latch: pending_b set by req_b=1 in any state except B_GO/B_REDAMBER, cleared on entering B_GO; pending_a symmetric.
REQ-010 A_GO exits on a tick edge when pending_b and (elapsed+1 >= T_MAX_GREEN, or elapsed+1 >= T_MIN_GREEN and req_a=0); with no pending_b A_GO holds indefinitely; B_GO symmetric.
REQ-011 fault=1 SHALL move any state to FAULT on the next edge regardless of tick, and clear all pending latches; FAULT holds while fault=1.
REQ-012 fault=0 in FAULT SHALL go to ALLRED_BA (elapsed 0) on the next edge.
REQ-013 Simultaneous fault and exit condition: fault wins.
REQ-014 phase codes: A_GO 0, A_AMBER 1, ALLRED_AB 2, B_REDAMBER 3, B_GO 4, B_AMBER 5, ALLRED_BA 6, A_REDAMBER 7, FAULT 8, PED_WALK 9.

Reset
REQ-015 rst_n=0 SHALL immediately force ALLRED_BA, elapsed 0, pending latches 0, lights_a=lights_b=100, phase=6, ped_walk=0.
REQ-016 Reset assertion mid-phase SHALL abandon the phase with no amber; release restarts per REQ-015.

Configuration
REQ-017 JUNCTION_PED_EN defined: ped_req latched into pending_ped (any state except PED_WALK); on ALLRED_* exit with pending_ped, enter PED_WALK (both 100, ped_walk=1) for T_WALK, clear pending_ped, then continue to the red+amber the all-red would have entered (direction bit held).
REQ-018 JUNCTION_PED_EN undefined: no ped_req/ped_walk ports, no PED_WALK state, code 9 unused.

Structure
REQ-019 Package junction_pkg SHALL hold the state enum with REQ-014 codes, light encoding constants, and elapsed width (8).
REQ-020 Sub-module phase_timer SHALL implement the clear/tick/saturating elapsed counter.

Verification
REQ-021 Reset release, no demand, defaults: 100/100 for 1 tick, A 110 for 1 tick, then A 001/B 100 held for 50 ticks.
REQ-022 In A_GO req_b pulsed 1 cycle at tick 1, req_a=0: A green totals 4 ticks, A 010 for 2, 100/100 for 1, B 110 for 1, then B 001.
REQ-023 req_a held 1, req_b pulsed: A green lasts exactly 12 ticks before A 010.
REQ-024 fault asserted during B_AMBER without tick: next cycle 100/100, phase 8; held 10 cycles; release -> phase 6 for 1 tick -> A 110.
REQ-025 Macro on: ped_req and req_b during A_GO: after ALLRED_AB, ped_walk=1 with 100/100 for 6 ticks, then B 110.
REQ-026 rst_n pulsed low during A_GO mid-tick: outputs 100/100 same cycle, no amber, sequence restarts per REQ-021.
